player_tracker: RTL

- Parametrised successor to the single-frog position tracker on the LED-matrix game.
- Owns the player's position on a ROWS x COLS grid and moves it one cell per button press, with optional hold-to-repeat.
- Detects collisions against a hazard mask and arrival at the goal row, and manages lives, score and a death/respawn/game-over state machine.
- Drives the green pixel plane consumed by the LED driver.

---
 rtl/game_pkg.sv | 24 ++
 rtl/move_repeater.sv | 63 ++++++
 rtl/player_tracker.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared types and default constants for the LED-matrix game blocks.
//   dir_t          : cursor direction after button priority encoding
//   player_state_t : life-cycle state of the player
//   GRID_ROWS/COLS : default matrix size
package game_pkg;

    localparam int GRID_ROWS = 16;
    localparam int GRID_COLS = 16;

    typedef enum logic [2:0] {
        DIR_NONE,
        DIR_RIGHT,
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT
    } dir_t;

    typedef enum logic [1:0] {
        ST_ALIVE,
        ST_DYING,
        ST_GAME_OVER
    } player_state_t;

endpackage

// File: rtl/move_repeater.sv
// Button priority encoder with press detection and hold-to-repeat.
//   clk, reset          : clock, async active-high reset
//   i_btn_*             : synchronised button levels
//   o_dir               : priority-encoded direction (right > up > down > left)
//   o_move_req          : a move is requested this cycle (combinational)
// A request fires on a new direction, then (when HOLD_CYCLES > 0) after the
// direction has been held HOLD_CYCLES cycles, then every REPEAT_CYCLES.
// REPEAT_CYCLES is expected to be in 1..HOLD_CYCLES.
module move_repeater
    import game_pkg::*;
#(
    parameter int HOLD_CYCLES   = 0,
    parameter int REPEAT_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn_up,
    input  logic i_btn_down,
    input  logic i_btn_left,
    input  logic i_btn_right,
    output dir_t o_dir,
    output logic o_move_req
);
    localparam int CNT_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] HOLD_V   = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] RELOAD_V = CNT_W'(HOLD_CYCLES - REPEAT_CYCLES);

    dir_t             r_prev_dir;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_new_press;
    logic             w_held;
    logic             w_repeat;

    always_comb begin
        o_dir = DIR_NONE;
        if (i_btn_right)     o_dir = DIR_RIGHT;
        else if (i_btn_up)   o_dir = DIR_UP;
        else if (i_btn_down) o_dir = DIR_DOWN;
        else if (i_btn_left) o_dir = DIR_LEFT;
    end

    // The incremented count is compared, so the first repeat lands exactly
    // HOLD_CYCLES cycles after the initial press.
    assign w_cnt_inc   = r_cnt + CNT_W'(1);
    assign w_new_press = (o_dir != DIR_NONE) && (o_dir != r_prev_dir);
    assign w_held      = (HOLD_CYCLES > 0) && (o_dir != DIR_NONE) && (o_dir == r_prev_dir);
    assign w_repeat    = w_held && (w_cnt_inc == HOLD_V);
    assign o_move_req  = w_new_press || w_repeat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev_dir <= DIR_NONE;
            r_cnt      <= '0;
        end else begin
            r_prev_dir <= o_dir;
            if (!w_held)       r_cnt <= '0;
            else if (w_repeat) r_cnt <= RELOAD_V;
            else               r_cnt <= w_cnt_inc;
        end
    end

endmodule

// File: rtl/player_tracker.sv
// Player position tracker for the LED-matrix game.
//   clk, reset                      : clock, async active-high reset
//   btn_up/down/left/right          : synchronised button levels
//   hazard_pixels [ROWS][COLS]      : 1 = hazard in that cell this cycle
//   grn_pixels    [ROWS][COLS]      : player plane (one bit, blinks while dying)
//   row, col, pos                   : current position, pos = row*COLS+col
//   lives, score                    : remaining lives, goals reached
//   move_pulse/hit_pulse/score_pulse: single-cycle event strobes
//   game_over                       : state is GAME_OVER
// Column 0 is the rightmost display column, so "right" decrements col.
module player_tracker
    import game_pkg::*;
#(
    parameter int ROWS          = GRID_ROWS,
    parameter int COLS          = GRID_COLS,
    parameter int START_ROW     = ROWS - 1,
    parameter int START_COL     = 6,
    parameter int GOAL_ROW      = 0,
    parameter int LIVES         = 3,
    parameter int HOLD_CYCLES   = 0,
    parameter int REPEAT_CYCLES = 4,
    parameter int DEATH_CYCLES  = 8,
    parameter int BLINK_SHIFT   = 1,
    parameter int SCORE_W       = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               btn_up,
    input  logic                               btn_down,
    input  logic                               btn_left,
    input  logic                               btn_right,
    input  logic [ROWS-1:0][COLS-1:0]          hazard_pixels,
    output logic [ROWS-1:0][COLS-1:0]          grn_pixels,
    output logic [$clog2(ROWS)-1:0]            row,
    output logic [$clog2(COLS)-1:0]            col,
    output logic [$clog2(ROWS*COLS)-1:0]       pos,
    output logic [2:0]                         lives,
    output logic [SCORE_W-1:0]                 score,
    output logic                               move_pulse,
    output logic                               hit_pulse,
    output logic                               score_pulse,
    output logic                               game_over
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int PW = $clog2(ROWS * COLS);
    // Death counter must be wide enough to carry the blink bit.
    localparam int DW = ($clog2(DEATH_CYCLES) > BLINK_SHIFT + 1) ? $clog2(DEATH_CYCLES) : BLINK_SHIFT + 1;

    localparam logic [RW-1:0] START_R = RW'(START_ROW);
    localparam logic [CW-1:0] START_C = CW'(START_COL);

    player_state_t    r_state;
    logic [RW-1:0]    r_row;
    logic [CW-1:0]    r_col;
    logic [2:0]       r_lives;
    logic [SCORE_W-1:0] r_score;
    logic [DW-1:0]    r_dcnt;
    logic             r_move_pulse;
    logic             r_hit_pulse;
    logic             r_score_pulse;

    dir_t             w_dir;
    logic             w_move_req;
    logic             w_blocked;
    logic [RW-1:0]    w_nrow;
    logic [CW-1:0]    w_ncol;
    logic             w_hit;
    logic             w_goal;
    logic             w_show;

    move_repeater #(
        .HOLD_CYCLES   (HOLD_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_rep (
        .clk         (clk),
        .reset       (reset),
        .i_btn_up    (btn_up),
        .i_btn_down  (btn_down),
        .i_btn_left  (btn_left),
        .i_btn_right (btn_right),
        .o_dir       (w_dir),
        .o_move_req  (w_move_req)
    );

    always_comb begin
        w_nrow    = r_row;
        w_ncol    = r_col;
        w_blocked = 1'b1;
        case (w_dir)
            DIR_RIGHT: begin w_blocked = (r_col == '0);             w_ncol = r_col - 1'b1; end
            DIR_UP:    begin w_blocked = (r_row == '0);             w_nrow = r_row - 1'b1; end
            DIR_DOWN:  begin w_blocked = (r_row == RW'(ROWS - 1));  w_nrow = r_row + 1'b1; end
            DIR_LEFT:  begin w_blocked = (r_col == CW'(COLS - 1));  w_ncol = r_col + 1'b1; end
            default:   ;
        endcase
    end

    assign w_hit  = hazard_pixels[r_row][r_col];
    assign w_goal = (r_row == RW'(GOAL_ROW));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_ALIVE;
            r_row         <= START_R;
            r_col         <= START_C;
            r_lives       <= 3'(LIVES);
            r_score       <= '0;
            r_dcnt        <= '0;
            r_move_pulse  <= 1'b0;
            r_hit_pulse   <= 1'b0;
            r_score_pulse <= 1'b0;
        end else begin
            r_move_pulse  <= 1'b0;
            r_hit_pulse   <= 1'b0;
            r_score_pulse <= 1'b0;
            case (r_state)
                // Collision beats goal beats move.
                ST_ALIVE: begin
                    if (w_hit) begin
                        r_hit_pulse <= 1'b1;
                        r_lives     <= (r_lives == 3'd0) ? 3'd0 : r_lives - 3'd1;
                        r_dcnt      <= '0;
                        r_state     <= ST_DYING;
                    end else if (w_goal) begin
                        r_score_pulse <= 1'b1;
                        if (r_score != '1) r_score <= r_score + 1'b1;
                        r_row <= START_R;
                        r_col <= START_C;
                    end else if (w_move_req && !w_blocked) begin
                        r_move_pulse <= 1'b1;
                        r_row        <= w_nrow;
                        r_col        <= w_ncol;
                    end
                end
                ST_DYING: begin
                    if (r_dcnt == DW'(DEATH_CYCLES - 1)) begin
                        if (r_lives == 3'd0) begin
                            r_state <= ST_GAME_OVER;
                        end else begin
                            r_state <= ST_ALIVE;
                            r_row   <= START_R;
                            r_col   <= START_C;
                        end
                    end else begin
                        r_dcnt <= r_dcnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_show = (r_state != ST_DYING) || !r_dcnt[BLINK_SHIFT];

    always_comb begin
        grn_pixels = '0;
        if (w_show) grn_pixels[r_row][r_col] = 1'b1;
    end

    assign row         = r_row;
    assign col         = r_col;
    assign pos         = PW'(r_row * COLS + r_col);
    assign lives       = r_lives;
    assign score       = r_score;
    assign move_pulse  = r_move_pulse;
    assign hit_pulse   = r_hit_pulse;
    assign score_pulse = r_score_pulse;
    assign game_over   = (r_state == ST_GAME_OVER);

endmodule
